// File: rtl/dpram_ba_q.sv
// dpram_ba_q: byte-addressable dual-port RAM with valid/ready requests and per-port response queues
module dpram_ba_q #(
  parameter int NBYTES = 4,
  parameter int DEPTH = 8192,
  parameter int RESP_DEPTH = 3,
  parameter string INIT_FILE = "",
  localparam int AW = $clog2(DEPTH) + $clog2(NBYTES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                t_p0_valid,
  output logic                t_p0_ready,
  input  logic                t_p0_we,
  input  logic [AW-1:0]       t_p0_addr,
  input  logic [NBYTES*8-1:0] t_p0_data,
  input  logic [NBYTES-1:0]   t_p0_mask,
  output logic                i_p0_valid,
  input  logic                i_p0_ready,
  output logic [NBYTES*8-1:0] i_p0_data,
  input  logic                t_p1_valid,
  output logic                t_p1_ready,
  input  logic                t_p1_we,
  input  logic [AW-1:0]       t_p1_addr,
  input  logic [NBYTES*8-1:0] t_p1_data,
  input  logic [NBYTES-1:0]   t_p1_mask,
  output logic                i_p1_valid,
  input  logic                i_p1_ready,
  output logic [NBYTES*8-1:0] i_p1_data
);
  localparam int W = NBYTES * 8;
  localparam int LB = $clog2(NBYTES);
  localparam int WW = $clog2(DEPTH);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [1:0] v, we, rdy, iv, ir, wr, rd;
  logic [AW-1:0] a [2];
  logic [W-1:0] d [2];
  logic [W-1:0] od [2];
  logic [NBYTES-1:0] m [2];
  logic [WW-1:0] wa [2];
  logic unused_lsb;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] x);
    return (x == PW'(RESP_DEPTH - 1)) ? '0 : x + 1'b1;
  endfunction
  assign v = {t_p1_valid, t_p0_valid};
  assign we = {t_p1_we, t_p0_we};
  assign ir = {i_p1_ready, i_p0_ready};
  assign a[0] = t_p0_addr;
  assign a[1] = t_p1_addr;
  assign d[0] = t_p0_data;
  assign d[1] = t_p1_data;
  assign m[0] = t_p0_mask;
  assign m[1] = t_p1_mask;
  assign wr = v & rdy & we;
  assign rd = v & rdy & ~we;
  assign t_p0_ready = rdy[0];
  assign t_p1_ready = rdy[1];
  assign i_p0_valid = iv[0];
  assign i_p1_valid = iv[1];
  assign i_p0_data = od[0];
  assign i_p1_data = od[1];
  assign unused_lsb = ^{t_p0_addr, t_p1_addr};
  always_ff @(posedge clk)
    for (int b = 0; b < NBYTES; b++) begin
      if (wr[1] && m[1][b]) mem[wa[1]][8*b +: 8] <= d[1][8*b +: 8];
      if (wr[0] && m[0][b]) mem[wa[0]][8*b +: 8] <= d[0][8*b +: 8];
    end
  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int Q = 1 - p;
    logic [W-1:0] rd_word, rd_q;
    logic [W-1:0] fifo [RESP_DEPTH];
    logic [PW-1:0] hd, tl;
    logic [CW-1:0] cnt;
    logic infl, pop;
    assign wa[p] = a[p][AW-1:LB];
    always_comb begin
      rd_word = mem[wa[p]];
`ifdef DPRAM_BYPASS_EN
      for (int b = 0; b < NBYTES; b++)
        if (wr[Q] && m[Q][b] && wa[Q] == wa[p]) rd_word[8*b +: 8] = d[Q][8*b +: 8];
`endif
    end
    assign pop = iv[p] & ir[p];
    assign iv[p] = cnt != '0;
    assign od[p] = iv[p] ? fifo[hd] : '0;
    assign rdy[p] = !rst && (int'(cnt) + int'(infl) < RESP_DEPTH);
    always_ff @(posedge clk) begin
      if (rd[p]) rd_q <= rd_word;
      if (infl) fifo[tl] <= rd_q;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        hd <= '0;
        tl <= '0;
        cnt <= '0;
        infl <= 1'b0;
      end else begin
        infl <= rd[p];
        if (infl) tl <= nxt(tl);
        if (pop) hd <= nxt(hd);
        cnt <= cnt + CW'(infl) - CW'(pop);
      end
  end
endmodule

// File: tb/tb_dpram_ba_q.sv
// tb_dpram_ba_q: directed self-checking bench for dpram_ba_q
module tb_dpram_ba_q;
    localparam int AW = 10;
    logic clk = 0, rst = 1;
    logic t_p0_valid = 0, t_p0_ready, t_p0_we = 0;
    logic [AW-1:0] t_p0_addr = 0;
    logic [31:0] t_p0_data = 0;
    logic [3:0] t_p0_mask = 0;
    logic i_p0_valid, i_p0_ready = 1;
    logic [31:0] i_p0_data;
    logic t_p1_valid = 0, t_p1_ready, t_p1_we = 0;
    logic [AW-1:0] t_p1_addr = 0;
    logic [31:0] t_p1_data = 0;
    logic [3:0] t_p1_mask = 0;
    logic i_p1_valid, i_p1_ready = 1;
    logic [31:0] i_p1_data;
    int checks = 0, errors = 0;

    dpram_ba_q #(.NBYTES(4), .DEPTH(256), .RESP_DEPTH(3)) dut (
        .clk(clk), .rst(rst),
        .t_p0_valid(t_p0_valid), .t_p0_ready(t_p0_ready), .t_p0_we(t_p0_we),
        .t_p0_addr(t_p0_addr), .t_p0_data(t_p0_data), .t_p0_mask(t_p0_mask),
        .i_p0_valid(i_p0_valid), .i_p0_ready(i_p0_ready), .i_p0_data(i_p0_data),
        .t_p1_valid(t_p1_valid), .t_p1_ready(t_p1_ready), .t_p1_we(t_p1_we),
        .t_p1_addr(t_p1_addr), .t_p1_data(t_p1_data), .t_p1_mask(t_p1_mask),
        .i_p1_valid(i_p1_valid), .i_p1_ready(i_p1_ready), .i_p1_data(i_p1_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE0000 + 32'(i) * 32'h00000101;
    endfunction

    task automatic set(input int p, input logic vl, input logic w, input int addr,
                       input logic [31:0] dat, input logic [3:0] msk);
        if (p == 0) begin
            t_p0_valid = vl; t_p0_we = w; t_p0_addr = AW'(addr); t_p0_data = dat; t_p0_mask = msk;
        end else begin
            t_p1_valid = vl; t_p1_we = w; t_p1_addr = AW'(addr); t_p1_data = dat; t_p1_mask = msk;
        end
    endtask

    task automatic do_req(input int p, input logic w, input int addr,
                          input logic [31:0] dat, input logic [3:0] msk);
        logic acc = 0;
        set(p, 1, w, addr, dat, msk);
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = (p == 0) ? t_p0_ready : t_p1_ready;
            @(posedge clk); #1;
        end
        set(p, 0, 0, 0, 0, 0);
        check("req_accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic get(input int p, input logic [31:0] exp, input string tag);
        logic found = 0;
        logic [31:0] got = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            if ((p == 0) ? i_p0_valid : i_p1_valid) begin
                found = 1;
                got = (p == 0) ? i_p0_data : i_p1_data;
            end
            @(posedge clk); #1;
        end
        check(tag, {31'd0, found, got}, {32'd1, exp});
    endtask

    task automatic rd(input int p, input int addr, input logic [31:0] exp, input string tag);
        do_req(p, 0, addr, 0, 0);
        get(p, exp, tag);
    endtask

    initial begin
        int k, gap, stall, last, acc, seen;
        logic took;
        logic [31:0] xexp;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy0", {63'd0, t_p0_ready}, 0);
        check("rst_rdy1", {63'd0, t_p1_ready}, 0);
        check("rst_vld0", {63'd0, i_p0_valid}, 0);
        check("rst_dat0", {32'd0, i_p0_data}, 0);
        rst = 0;
        #1;
        check("rel_rdy0", {63'd0, t_p0_ready}, 1);
        check("rel_rdy1", {63'd0, t_p1_ready}, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) do_req(1, 1, i * 4, pat(i), 4'hF);

        k = 0; gap = 0; stall = 0; last = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                set(1, 1, 0, c * 4, 0, 0);
                if (!t_p1_ready) stall++;
            end else set(1, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            if (i_p1_valid) begin
                if (k > 0 && c != last + 1) gap++;
                check($sformatf("stream_%0d", k), {32'd0, i_p1_data}, {32'd0, pat(k)});
                k++;
                last = c;
            end
        end
        check("stream_cnt", 64'(k), 16);
        check("stream_gap", 64'(gap), 0);
        check("stream_stall", 64'(stall), 0);

        do_req(0, 1, 'h10, 32'hAABBCCDD, 4'hF);
        do_req(0, 1, 'h12, 32'h11223344, 4'h5);
        set(0, 1, 0, 'h10, 0, 0);
        check("lat_rdy", {63'd0, t_p0_ready}, 1);
        @(posedge clk); #1;
        set(0, 0, 0, 0, 0, 0);
        check("lat_e1", {63'd0, i_p0_valid}, 0);
        @(posedge clk); #1;
        check("lat_e2", {63'd0, i_p0_valid}, 1);
        check("mask_data", {32'd0, i_p0_data}, {32'd0, 32'hAA22CC44});
        @(posedge clk); #1;
        check("lat_pop", {63'd0, i_p0_valid}, 0);

        i_p0_ready = 0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            set(0, 1, 0, acc * 4, 0, 0);
            took = t_p0_ready;
            @(posedge clk); #1;
            if (took) acc++;
        end
        check("bp_acc", 64'(acc), 3);
        check("bp_rdy", {63'd0, t_p0_ready}, 0);
        check("bp_head", {32'd0, i_p0_data}, {32'd0, pat(0)});
        i_p0_ready = 1;
        @(posedge clk); #1;
        i_p0_ready = 0;
        check("bp_rdy_pop", {63'd0, t_p0_ready}, 1);
        @(posedge clk); #1;
        set(0, 0, 0, 0, 0, 0);
        check("bp_rdy_full", {63'd0, t_p0_ready}, 0);
        i_p0_ready = 1;
        get(0, pat(1), "bp_r1");
        get(0, pat(2), "bp_r2");
        get(0, pat(3), "bp_r3");

        do_req(0, 1, 'h14, 0, 4'hF);
        set(0, 1, 1, 'h14, 32'h000000FF, 4'h1);
        set(1, 1, 1, 'h14, 32'h0000EE00, 4'h3);
        @(posedge clk); #1;
        set(0, 0, 0, 0, 0, 0);
        set(1, 0, 0, 0, 0, 0);
        rd(0, 'h14, 32'h0000EEFF, "collide");

        do_req(0, 1, 9 * 4, 32'hDEADBEEF, 4'hF);
`ifdef DPRAM_BYPASS_EN
        xexp = 32'h12345678;
`else
        xexp = 32'hDEADBEEF;
`endif
        set(0, 1, 1, 9 * 4, 32'h12345678, 4'hF);
        set(1, 1, 0, 9 * 4, 0, 0);
        @(posedge clk); #1;
        set(0, 0, 0, 0, 0, 0);
        set(1, 0, 0, 0, 0, 0);
        get(1, xexp, "xport");
        rd(0, 9 * 4, 32'h12345678, "xport_after");

        i_p0_ready = 0;
        for (int c = 0; c < 3; c++) begin
            set(0, 1, 0, c * 4, 0, 0);
            @(posedge clk); #1;
        end
        set(0, 0, 0, 0, 0, 0);
        check("pre_rst_vld", {63'd0, i_p0_valid}, 1);
        rst = 1;
        #1;
        check("mid_rst_vld", {63'd0, i_p0_valid}, 0);
        check("mid_rst_dat", {32'd0, i_p0_data}, 0);
        check("mid_rst_rdy", {63'd0, t_p0_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        check("post_rst_rdy", {63'd0, t_p0_ready}, 1);
        i_p0_ready = 1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (i_p0_valid) seen++;
        end
        check("no_stale", 64'(seen), 0);
        rd(0, 9 * 4, 32'h12345678, "mem_kept9");
        rd(0, 'h10, 32'hAA22CC44, "mem_kept4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
